// File: rtl/rv32_mem_arbiter.sv
// Shares one memory bus between instruction fetch and data load/store.
// Data has fixed priority, bounded by a starvation counter that eventually forces an instruction grant.
module rv32_mem_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int COUNT_WIDTH    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_DATA_BURST);

  state_t                 state, state_nxt;
  logic [COUNT_WIDTH-1:0] count, count_nxt;
  logic [31:0]            address_nxt;
  logic                   read_nxt;
  logic [3:0]             mask_nxt;
  logic [31:0]            write_value_nxt;
  logic                   data_req;
  logic                   instr_req;
  logic                   instr_starved;

  assign data_req      = data_read_in | (|data_write_mask_in);
  assign instr_req     = instr_read_in;
  assign instr_starved = instr_req && (count == MAX_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state               <= IDLE;
      count               <= '0;
      bus_address_out     <= '0;
      bus_read_out        <= 1'b0;
      bus_write_mask_out  <= '0;
      bus_write_value_out <= '0;
    end else begin
      state               <= state_nxt;
      count               <= count_nxt;
      bus_address_out     <= address_nxt;
      bus_read_out        <= read_nxt;
      bus_write_mask_out  <= mask_nxt;
      bus_write_value_out <= write_value_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    address_nxt     = bus_address_out;
    read_nxt        = bus_read_out;
    mask_nxt        = bus_write_mask_out;
    write_value_nxt = bus_write_value_out;
    case (state)
      IDLE: begin
        if (data_req && !instr_starved) begin
          state_nxt       = DATA;
          address_nxt     = data_address_in;
          read_nxt        = data_read_in;
          mask_nxt        = data_write_mask_in;
          write_value_nxt = data_write_value_in;
          // Count only grants that actually made a waiting fetch wait longer.
          if (!instr_req)
            count_nxt = '0;
          else if (count != MAX_CNT)
            count_nxt = count + COUNT_WIDTH'(1);
        end else if (instr_req) begin
          state_nxt   = INSTR;
          address_nxt = instr_address_in;
          read_nxt    = 1'b1;
          mask_nxt    = '0;
          count_nxt   = '0;
        end
      end
      INSTR, DATA: begin
        if (bus_ready_in) begin
          state_nxt = IDLE;
          read_nxt  = 1'b0;
          mask_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completion is forwarded in the same cycle the bus finishes.
  assign instr_ready_out      = (state == INSTR) && bus_ready_in;
  assign data_ready_out       = (state == DATA) && bus_ready_in;
  assign instr_read_value_out = bus_read_value_in;
  assign data_read_value_out  = bus_read_value_in;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_rv32_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr_address_in = '0;
  logic        instr_read_in = 1'b0;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [31:0] data_address_in = '0;
  logic        data_read_in = 1'b0;
  logic [3:0]  data_write_mask_in = '0;
  logic [31:0] data_write_value_in = '0;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic [31:0] bus_address_out;
  logic        bus_read_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in = '0;
  logic        bus_ready_in = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.MAX_DATA_BURST(MAXB), .COUNT_WIDTH(3)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .instr_address_in    (instr_address_in),
    .instr_read_in       (instr_read_in),
    .instr_read_value_out(instr_read_value_out),
    .instr_ready_out     (instr_ready_out),
    .data_address_in     (data_address_in),
    .data_read_in        (data_read_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .data_ready_out      (data_ready_out),
    .bus_address_out     (bus_address_out),
    .bus_read_out        (bus_read_out),
    .bus_write_mask_out  (bus_write_mask_out),
    .bus_write_value_out (bus_write_value_out),
    .bus_read_value_in   (bus_read_value_in),
    .bus_ready_in        (bus_ready_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_read_in       = 1'b0;
    instr_address_in    = '0;
    data_read_in        = 1'b0;
    data_write_mask_in  = '0;
    data_address_in     = '0;
    data_write_value_in = '0;
    bus_ready_in        = 1'b0;
    bus_read_value_in   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    instr_read_in    = 1'b1;
    instr_address_in = 32'h0000_0040;
    data_read_in     = 1'b1;
    data_address_in  = 32'h0000_0080;
    bus_ready_in     = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if (bus_read_out !== 1'b0) begin
        failures++; $display("FAIL reset_bus_read cyc=%0d got=%b exp=0", c, bus_read_out);
      end
      checks++;
      if (bus_write_mask_out !== 4'b0) begin
        failures++; $display("FAIL reset_bus_mask cyc=%0d got=%h exp=0", c, bus_write_mask_out);
      end
      checks++;
      if (instr_ready_out !== 1'b0 || data_ready_out !== 1'b0) begin
        failures++; $display("FAIL reset_ready cyc=%0d got=%b%b exp=00", c, instr_ready_out, data_ready_out);
      end
    end
    checks++;
    if (bus_address_out !== 32'h0) begin
      failures++; $display("FAIL reset_bus_addr got=%h exp=0", bus_address_out);
    end
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (bus_read_out !== 1'b1 || bus_address_out !== 32'h0000_0080) begin
      failures++; $display("FAIL reset_release_data_grant got rd=%b addr=%h exp rd=1 addr=00000080", bus_read_out, bus_address_out);
    end
    checks++;
    if (data_ready_out !== 1'b0 || instr_ready_out !== 1'b0) begin
      failures++; $display("FAIL reset_release_ready got=%b%b exp=00", instr_ready_out, data_ready_out);
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    instr_read_in     = 1'b1;
    instr_address_in  = 32'h0000_0100;
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (instr_ready_out !== 1'b0 || bus_read_out !== 1'b0) begin
      failures++; $display("FAIL fetch_cycle_n got ready=%b rd=%b exp ready=0 rd=0", instr_ready_out, bus_read_out);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus_address_out !== 32'h0000_0100 || bus_read_out !== 1'b1) begin
      failures++; $display("FAIL fetch_bus got addr=%h rd=%b exp addr=00000100 rd=1", bus_address_out, bus_read_out);
    end
    checks++;
    if (instr_ready_out !== 1'b1 || instr_read_value_out !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL fetch_ready got ready=%b val=%h exp ready=1 val=deadbeef", instr_ready_out, instr_read_value_out);
    end
    checks++;
    if (data_ready_out !== 1'b0) begin
      failures++; $display("FAIL fetch_data_ready got=%b exp=0", data_ready_out);
    end
    tick();
    instr_read_in = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_read_out !== 1'b0 || instr_ready_out !== 1'b0) begin
      failures++; $display("FAIL fetch_after got rd=%b ready=%b exp rd=0 ready=0", bus_read_out, instr_ready_out);
    end
  endtask

  task automatic test_store_wait();
    do_reset();
    data_write_mask_in  = 4'b0011;
    data_write_value_in = 32'h1234_5678;
    data_address_in     = 32'h0000_0200;
    bus_ready_in        = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus_ready_in = (k == 3);
      @(negedge clk);
      checks++;
      if (bus_address_out !== 32'h0000_0200 || bus_write_mask_out !== 4'b0011 ||
          bus_write_value_out !== 32'h1234_5678 || bus_read_out !== 1'b0) begin
        failures++;
        $display("FAIL store_bus k=%0d got addr=%h mask=%h val=%h rd=%b exp addr=00000200 mask=3 val=12345678 rd=0",
                 k, bus_address_out, bus_write_mask_out, bus_write_value_out, bus_read_out);
      end
      checks++;
      if (data_ready_out !== (k == 3) || instr_ready_out !== 1'b0) begin
        failures++; $display("FAIL store_ready k=%0d got d=%b i=%b exp d=%b i=0", k, data_ready_out, instr_ready_out, (k == 3));
      end
    end
    tick();
    data_write_mask_in = 4'b0;
    bus_ready_in       = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_write_mask_out !== 4'b0 || bus_address_out !== 32'h0000_0200 || bus_write_value_out !== 32'h1234_5678) begin
      failures++; $display("FAIL store_done got mask=%h addr=%h val=%h exp mask=0 addr=00000200 val=12345678",
                           bus_write_mask_out, bus_address_out, bus_write_value_out);
    end
  endtask

  task automatic test_contention();
    int grants[$];
    bit both;
    do_reset();
    instr_read_in    = 1'b1;
    instr_address_in = 32'h0000_1000;
    data_read_in     = 1'b1;
    data_address_in  = 32'h0000_2000;
    bus_ready_in     = 1'b1;
    both = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      @(negedge clk);
      if (instr_ready_out && data_ready_out) both = 1'b1;
      if (data_ready_out) grants.push_back(2);
      else if (instr_ready_out) grants.push_back(1);
    end
    checks++;
    if (both) begin
      failures++; $display("FAIL contention_both_ready got=1 exp=0");
    end
    checks++;
    if (grants.size() != 15) begin
      failures++; $display("FAIL contention_grant_count got=%0d exp=15", grants.size());
    end
    for (int i = 0; i < grants.size() && i < 15; i++) begin
      checks++;
      if (grants[i] != ((i % (MAXB + 1) == MAXB) ? 1 : 2)) begin
        failures++; $display("FAIL contention_order idx=%0d got=%0d exp=%0d (1=I 2=D)", i, grants[i], (i % (MAXB + 1) == MAXB) ? 1 : 2);
      end
    end
  endtask

  task automatic test_starvation_reset();
    int grants[$];
    int dcount;
    do_reset();
    data_read_in    = 1'b1;
    data_address_in = 32'h0000_3000;
    bus_ready_in    = 1'b1;
    dcount = 0;
    for (int c = 0; c < 30 && grants.size() < 8; c++) begin
      tick();
      if (dcount >= 3) begin
        instr_read_in    = 1'b1;
        instr_address_in = 32'h0000_4000;
      end
      @(negedge clk);
      if (data_ready_out) begin grants.push_back(2); dcount++; end
      else if (instr_ready_out) grants.push_back(1);
    end
    checks++;
    if (grants.size() != 8) begin
      failures++; $display("FAIL starve_grant_count got=%0d exp=8", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      checks++;
      if (grants[i] != ((i == 7) ? 1 : 2)) begin
        failures++; $display("FAIL starve_order idx=%0d got=%0d exp=%0d (1=I 2=D)", i, grants[i], (i == 7) ? 1 : 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    data_write_mask_in  = 4'b1111;
    data_write_value_in = 32'hCAFE_F00D;
    data_address_in     = 32'h0000_0300;
    bus_ready_in        = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus_write_mask_out !== 4'b1111) begin
      failures++; $display("FAIL midreset_pre got mask=%h exp=f", bus_write_mask_out);
    end
    reset_n = 1'b0;
    tick();
    reset_n            = 1'b1;
    data_write_mask_in = 4'b0;
    bus_ready_in       = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_write_mask_out !== 4'b0 || bus_read_out !== 1'b0) begin
      failures++; $display("FAIL midreset_strobes got mask=%h rd=%b exp mask=0 rd=0", bus_write_mask_out, bus_read_out);
    end
    seen = data_ready_out;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      if (data_ready_out) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL midreset_no_ready got=1 exp=0");
    end
  endtask

  task automatic test_idle_ready();
    bit bad;
    do_reset();
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h5555_AAAA;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      if (instr_ready_out || data_ready_out || bus_read_out || bus_write_mask_out != 4'b0 || bus_address_out != 32'h0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL idle_ready_ignored got=changed exp=unchanged");
    end
  endtask

  task automatic test_random();
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_waits;   // data grants a pending fetch has already sat through
    logic [31:0] m_addr, m_wval;
    logic        m_rd;
    logic [3:0]  m_mask;
    bit          i_act, d_act, i_done, d_done, exp_i, exp_d, ireq, dreq;
    int          errs;
    do_reset();
    m_owner = 0; m_waits = 0; m_addr = '0; m_wval = '0; m_rd = 1'b0; m_mask = '0;
    i_act = 0; d_act = 0; i_done = 0; d_done = 0;
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (i_done) begin i_act = 0; instr_read_in = 1'b0; end
      if (d_done) begin d_act = 0; data_read_in = 1'b0; data_write_mask_in = 4'b0; end
      if (!i_act && ($urandom % 3 == 0)) begin
        i_act = 1; instr_read_in = 1'b1; instr_address_in = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_act && ($urandom % 2 == 0)) begin
        d_act = 1;
        data_address_in     = $urandom & 32'hFFFF_FFFC;
        data_write_value_in = $urandom;
        if ($urandom % 2 == 0) begin
          data_read_in = 1'b1; data_write_mask_in = 4'b0;
        end else begin
          data_read_in = 1'b0; data_write_mask_in = 4'($urandom_range(1, 15));
        end
      end
      bus_ready_in      = ($urandom % 3 != 0);
      bus_read_value_in = $urandom;
      @(negedge clk);
      exp_i = (m_owner == 1) && bus_ready_in;
      exp_d = (m_owner == 2) && bus_ready_in;
      checks++;
      if (bus_address_out !== m_addr || bus_read_out !== m_rd || bus_write_mask_out !== m_mask ||
          bus_write_value_out !== m_wval || instr_ready_out !== exp_i || data_ready_out !== exp_d ||
          (exp_i && instr_read_value_out !== bus_read_value_in) ||
          (exp_d && data_read_value_out !== bus_read_value_in)) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle c=%0d got addr=%h rd=%b mask=%h wv=%h ir=%b dr=%b exp addr=%h rd=%b mask=%h wv=%h ir=%b dr=%b",
                   c, bus_address_out, bus_read_out, bus_write_mask_out, bus_write_value_out, instr_ready_out,
                   data_ready_out, m_addr, m_rd, m_mask, m_wval, exp_i, exp_d);
      end
      i_done = exp_i;
      d_done = exp_d;
      // Transaction-level model: data wins unless the fetch has already waited MAXB data grants.
      if (m_owner == 0) begin
        dreq = data_read_in || (data_write_mask_in != 4'b0);
        ireq = instr_read_in;
        if (dreq && !(ireq && m_waits == MAXB)) begin
          m_owner = 2;
          m_addr  = data_address_in;
          m_rd    = data_read_in;
          m_mask  = data_write_mask_in;
          m_wval  = data_write_value_in;
          m_waits = ireq ? ((m_waits < MAXB) ? m_waits + 1 : MAXB) : 0;
        end else if (ireq) begin
          m_owner = 1;
          m_addr  = instr_address_in;
          m_rd    = 1'b1;
          m_mask  = 4'b0;
          m_waits = 0;
        end
      end else if (bus_ready_in) begin
        m_owner = 0;
        m_rd    = 1'b0;
        m_mask  = 4'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_contention();
    test_starvation_reset();
    test_reset_mid();
    test_idle_ready();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
